sel_stream: RTL and testbench



---
 rtl/sel_stream.sv | 162 ++++++++++++++++
 tb/tb_sel_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_stream.sv
// sel_stream: N-channel packet-locked stream selector (one-hot sel_i or round-robin), build option SEL_STREAM_ERR_EN adds err_o.
// Latency: an accepted beat appears on out_vld_o the following cycle; 1 beat/cycle sustained.
// Backpressure: 2-entry output buffer; inputs stall only when it is full, in_rdy_o never depends on out_rdy_i.
module sel_stream #(
   parameter int  W     = 32,
   parameter int  N     = 4,
   parameter int  RR_EN = 0,
   localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic [N-1:0]    in_vld_i,
   input  logic [N*W-1:0]  in_data_i,
   input  logic [N-1:0]    in_last_i,
   output logic [N-1:0]    in_rdy_o,
   input  logic [N-1:0]    sel_i,
   output logic            out_vld_o,
   output logic [W-1:0]    out_data_o,
   output logic            out_last_o,
   output logic [SW-1:0]   out_src_o,
   input  logic            out_rdy_i
`ifdef SEL_STREAM_ERR_EN
   ,
   output logic            err_o
`endif
);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   typedef struct packed {
      logic [W-1:0]  data;
      logic          last;
      logic [SW-1:0] src;
   } beat_t;

   state_t        state_q;
   state_t        state_d;
   logic [SW-1:0] lock_ch;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] cand;
   logic [SW-1:0] idx;
   logic          cand_ok;
   logic [1:0]    cnt;
   beat_t         slot0;
   beat_t         slot1;
   beat_t         in_beat;
   logic          take;
   logic          pop;

   // Candidate channel: locked channel mid-packet, otherwise sel_i or round-robin search.
   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      idx     = '0;
      if (state_q == S_LOCKED) begin
         cand    = lock_ch;
         cand_ok = 1'b1;
      end else if (RR_EN != 0) begin
         // Walk from farthest to nearest so the nearest valid channel after rr_ptr wins.
         for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(rr_ptr) + k) % N);
            if (in_vld_i[idx]) begin
               cand    = idx;
               cand_ok = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (sel_i[i] && in_vld_i[i]) begin
               cand    = SW'(i);
               cand_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_rdy_o = '0;
      if (cand_ok && (cnt != 2'd2)) begin
         in_rdy_o[cand] = 1'b1;
      end
   end

   assign take         = |(in_vld_i & in_rdy_o);
   assign in_beat.data = in_data_i[int'(cand)*W +: W];
   assign in_beat.last = in_last_i[cand];
   assign in_beat.src  = cand;

   assign out_vld_o  = (cnt != 2'd0);
   assign out_data_o = slot0.data;
   assign out_last_o = slot0.last;
   assign out_src_o  = slot0.src;
   assign pop        = out_vld_o && out_rdy_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (take && !in_beat.last) state_d = S_LOCKED;
         S_LOCKED: if (take && in_beat.last)  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         lock_ch <= '0;
         rr_ptr  <= SW'(N - 1);
      end else begin
         state_q <= state_d;
         if (take && (state_q == S_IDLE)) begin
            lock_ch <= cand;
            rr_ptr  <= cand;
         end
      end
   end

   // slot0 is the head and drives the outputs directly; a push never lands in a full buffer.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt   <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({take, pop})
            2'b10: begin
               if (cnt == 2'd0) slot0 <= in_beat;
               else             slot1 <= in_beat;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= in_beat;
               end else begin
                  slot0 <= slot1;
                  slot1 <= in_beat;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SEL_STREAM_ERR_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_o <= 1'b0;
      end else begin
         err_o <= (RR_EN == 0) && (state_q == S_IDLE) && (|in_vld_i) &&
                  ((sel_i & (sel_i - N'(1))) != '0);
      end
   end
`endif

endmodule

// File: tb/tb_sel_stream.sv
// Bench for sel_stream: one sel_i-driven and one round-robin instance, per-channel beat scoreboard,
// directed scenarios followed by randomized packet traffic.
module tb_sel_stream;
   localparam int W = 8;
   localparam int N = 4;

   logic           clk    = 1'b0;
   logic           arst_n = 1'b0;
   logic [N-1:0]   vld  [2];
   logic [N*W-1:0] dat  [2];
   logic [N-1:0]   lst  [2];
   logic [N-1:0]   rdy  [2];
   logic [N-1:0]   sel  [2];
   logic           ovld [2];
   logic           olast[2];
   logic           ordy [2];
   logic [W-1:0]   odat [2];
   logic [1:0]     osrc [2];
`ifdef SEL_STREAM_ERR_EN
   logic           err  [2];
`endif

   logic [8:0]     sendq[2][N][$];
   logic [8:0]     expq [2][N][$];
   int             srclog[2][$];
   logic [N-1:0]   acc   [2];
   logic           hold_v[2];
   logic [10:0]    hold_d[2];
   logic           in_pkt[2];
   logic [1:0]     cur_src[2];
   int             checks  = 0;
   int             passes  = 0;
   int             gap_pct = 0;

   always #5 clk = ~clk;

   sel_stream #(.W(W), .N(N), .RR_EN(0)) u_sel (
      .clk(clk), .arst_n(arst_n),
      .in_vld_i(vld[0]), .in_data_i(dat[0]), .in_last_i(lst[0]), .in_rdy_o(rdy[0]),
      .sel_i(sel[0]),
      .out_vld_o(ovld[0]), .out_data_o(odat[0]), .out_last_o(olast[0]), .out_src_o(osrc[0]),
      .out_rdy_i(ordy[0])
`ifdef SEL_STREAM_ERR_EN
      , .err_o(err[0])
`endif
   );

   sel_stream #(.W(W), .N(N), .RR_EN(1)) u_rr (
      .clk(clk), .arst_n(arst_n),
      .in_vld_i(vld[1]), .in_data_i(dat[1]), .in_last_i(lst[1]), .in_rdy_o(rdy[1]),
      .sel_i(sel[1]),
      .out_vld_o(ovld[1]), .out_data_o(odat[1]), .out_last_o(olast[1]), .out_src_o(osrc[1]),
      .out_rdy_i(ordy[1])
`ifdef SEL_STREAM_ERR_EN
      , .err_o(err[1])
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
   endtask

   // Stimulus and scoreboard expectation are queued together.
   task automatic push_beat(input int d, input int c, input logic [7:0] v, input logic l);
      sendq[d][c].push_back({l, v});
      expq[d][c].push_back({l, v});
   endtask

   task automatic wait_acc(input int d, input int c, input int budget);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         hit = vld[d][c] && rdy[d][c];
      end
      chk("acc_wait", hit, 1);
   endtask

   task automatic wait_drain(input int budget, input bit rot);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk); #1;
         if (rot) sel[0] = 4'b0001 << $urandom_range(3);
         @(negedge clk);
         done = !(ovld[0] || ovld[1]);
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++)
               if (expq[d][c].size() != 0) done = 1'b0;
      end
      chk("drain", done, 1);
   endtask

   // Producers: each channel presents its queue head, holding it until accepted (random gaps allowed).
   initial begin
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
               if (acc[d][c] && sendq[d][c].size() != 0) sendq[d][c].delete(0);
               if (sendq[d][c].size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
                  vld[d][c] = 1'b1;
                  {lst[d][c], dat[d][c*W +: W]} = sendq[d][c][0];
               end else begin
                  vld[d][c] = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: per-channel ordering, packet contiguity, output hold under stall.
   initial begin
      logic [9:0] eb;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            acc[d] = vld[d] & rdy[d];
            if (!arst_n) begin
               hold_v[d] = 1'b0;
               in_pkt[d] = 1'b0;
            end else begin
               chk("rdy_onehot", ($countones(rdy[d]) <= 1), 1);
`ifdef SEL_STREAM_ERR_EN
               if (d == 1) chk("rr_err_quiet", err[1], 0);
`endif
               if (hold_v[d]) chk("out_hold", {ovld[d], olast[d], osrc[d], odat[d]}, {1'b1, hold_d[d]});
               hold_v[d] = ovld[d] && !ordy[d];
               hold_d[d] = {olast[d], osrc[d], odat[d]};
               if (ovld[d] && ordy[d]) begin
                  srclog[d].push_back(int'(osrc[d]));
                  if (in_pkt[d]) chk("pkt_contig", osrc[d], cur_src[d]);
                  if (expq[d][osrc[d]].size() != 0) eb = {1'b0, expq[d][osrc[d]].pop_front()};
                  else eb = 10'h3ff;
                  chk("beat", {1'b0, olast[d], odat[d]}, eb);
                  in_pkt[d]  = !olast[d];
                  cur_src[d] = osrc[d];
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] t1v[3];
      int n;
      int r;
      t1v = '{8'h11, 8'h22, 8'h33};
      for (int d = 0; d < 2; d++) begin
         vld[d] = '0; dat[d] = '0; lst[d] = '0; sel[d] = '0; ordy[d] = 1'b1;
         acc[d] = '0; hold_v[d] = 1'b0; in_pkt[d] = 1'b0; cur_src[d] = '0;
      end
      arst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_vld", ovld[d], 0);
         chk("rst_data", odat[d], 0);
         chk("rst_last", olast[d], 0);
         chk("rst_src", osrc[d], 0);
      end
      arst_n = 1'b1;

      // 3-beat packet on ch2 via sel_i
      @(posedge clk); #1;
      sel[0] = 4'b0100;
      push_beat(0, 2, 8'h11, 1'b0);
      push_beat(0, 2, 8'h22, 1'b0);
      push_beat(0, 2, 8'h33, 1'b1);
      wait_acc(0, 2, 20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_vld", ovld[0], 1);
         chk("t1_data", odat[0], t1v[i]);
         chk("t1_last", olast[0], (i == 2));
         chk("t1_src", osrc[0], 2);
      end
      @(negedge clk);
      chk("t1_empty", ovld[0], 0);

      // Lock holds against a sel_i switch
      @(posedge clk); #1;
      sel[0] = 4'b0001;
      for (int i = 0; i < 4; i++) push_beat(0, 0, 8'h40 + 8'(i), (i == 3));
      push_beat(0, 3, 8'hC0, 1'b0);
      push_beat(0, 3, 8'hC1, 1'b1);
      wait_acc(0, 0, 20);
      @(posedge clk); #1;
      sel[0] = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t2_rdy3_held", rdy[0][3], 0);
         if (vld[0][0] && rdy[0][0] && lst[0][0]) break;
      end
      @(negedge clk);
      chk("t2_rdy3_grant", rdy[0][3] & vld[0][3], 1);
      wait_drain(50, 0);

      // Round-robin with all channels holding single-beat packets
      @(posedge clk); #1;
      srclog[1].delete();
      for (int rep = 0; rep < 2; rep++)
         for (int c = 0; c < N; c++) push_beat(1, c, 8'(c * 16 + rep), 1'b1);
      wait_drain(60, 0);
      chk("t3_count", srclog[1].size(), 8);
      for (int i = 0; i < srclog[1].size() && i < 8; i++) chk("t3_src", srclog[1][i], i % 4);

      // Output stall: buffer fills with two beats then holds
      @(posedge clk); #1;
      sel[0]  = 4'b0010;
      ordy[0] = 1'b0;
      push_beat(0, 1, 8'hA0, 1'b0);
      push_beat(0, 1, 8'hA1, 1'b0);
      push_beat(0, 1, 8'hA2, 1'b1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (vld[0][1] && rdy[0][1]) n++;
      end
      chk("t4_accepts", n, 2);
      chk("t4_rdy_full", rdy[0][1], 0);
      chk("t4_vld", ovld[0], 1);
      chk("t4_data", odat[0], 8'hA0);
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      wait_drain(40, 0);

      // Multi-hot sel_i: lowest index first
      @(posedge clk); #1;
      srclog[0].delete();
      sel[0] = 4'b0110;
      push_beat(0, 1, 8'h51, 1'b1);
      push_beat(0, 2, 8'h62, 1'b1);
      wait_acc(0, 1, 20);
      chk("t6_rdy2_low", rdy[0][2], 0);
      @(posedge clk); #1;
      sel[0] = 4'b0100;
`ifdef SEL_STREAM_ERR_EN
      @(negedge clk);
      chk("t6_err_pulse", err[0], 1);
      @(negedge clk);
      chk("t6_err_clear", err[0], 0);
`endif
      wait_drain(40, 0);
      chk("t6_first_src", (srclog[0].size() != 0) ? srclog[0][0] : -1, 1);

      // Reset while locked with a full buffer
      @(posedge clk); #1;
      sel[0]  = 4'b0001;
      ordy[0] = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(0, 0, 8'h70 + 8'(i), (i == 3));
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clk);
         if (vld[0][0] && rdy[0][0]) n++;
      end
      @(negedge clk);
      chk("t5_full", ovld[0], 1);
      sel[0] = 4'b0000;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N; c++) begin
            sendq[d][c].delete();
            expq[d][c].delete();
         end
      arst_n = 1'b0;
      #1;
      chk("t5_vld", ovld[0], 0);
      chk("t5_data", odat[0], 0);
      chk("t5_src", osrc[0], 0);
      repeat (2) @(negedge clk);
      arst_n  = 1'b1;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      srclog[1].delete();
      push_beat(1, 3, 8'hD3, 1'b1);
      push_beat(1, 0, 8'hD0, 1'b1);
      wait_drain(40, 0);
      chk("t5_rr_first", (srclog[1].size() > 1) ? srclog[1][0] : -1, 0);
      chk("t5_rr_second", (srclog[1].size() > 1) ? srclog[1][1] : -1, 3);

      // Randomized packet traffic on both instances
      gap_pct = 25;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk); #1;
         ordy[0] = ($urandom_range(3) != 0);
         ordy[1] = ($urandom_range(3) != 0);
         r = int'($urandom_range(7));
         sel[0] = (r < 4) ? (4'b0001 << r) : 4'($urandom);
         sel[1] = 4'($urandom);
         if ($urandom_range(3) == 0) begin
            int d, c, len;
            d   = int'($urandom_range(1));
            c   = int'($urandom_range(3));
            len = int'($urandom_range(4, 1));
            for (int j = 0; j < len; j++) push_beat(d, c, {2'(c), 6'($urandom)}, (j == len - 1));
         end
      end
      gap_pct = 0;
      ordy[0] = 1'b1;
      ordy[1] = 1'b1;
      wait_drain(3000, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
